// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one RV32I ALU between N requesters (2..4).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no pointer).
module alu_arbiter #(
    parameter int N = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [4*N-1:0]  req_opc,
    input  logic [N-1:0]    req_sel_pc,
    input  logic [32*N-1:0] req_pc,
    input  logic [32*N-1:0] req_reg1,
    input  logic [32*N-1:0] req_src2,
    output logic [3:0]      alu_opc,
    output logic            alu_sel_pc,
    output logic [31:0]     alu_pc,
    output logic [31:0]     alu_reg1,
    output logic [31:0]     alu_src2,
    input  logic [31:0]     alu_result,
    output logic            rsp_valid,
    output logic [1:0]      rsp_id,
    output logic [31:0]     rsp_data,
    input  logic            rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [N-1:0]   grant_s;
    logic [1:0]     grant_idx_s;
    logic           found_s;
    logic           hit_s;
    logic           open_s;
    logic           accept_s;
    logic [3:0]     sel_opc_s;
    logic           sel_pc_sel_s;
    logic [31:0]    sel_pc_s;
    logic [31:0]    sel_reg1_s;
    logic [31:0]    sel_src2_s;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [1:0]     ptr_r;
`endif

    // Grant selection: first valid requester in search order, one-hot or zero.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = 2'd0;
        found_s     = 1'b0;
        hit_s       = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) begin
            hit_s       = !found_s && req_valid[i];
            grant_s[i]  = hit_s;
            grant_idx_s = hit_s ? 2'(i) : grant_idx_s;
            found_s     = found_s | hit_s;
        end
`else
        // Search starts just after the last accepted index and wraps.
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                hit_s       = !found_s && req_valid[i] && (i == ((int'(ptr_r) + k) % N));
                grant_s[i]  = grant_s[i] | hit_s;
                grant_idx_s = hit_s ? 2'(i) : grant_idx_s;
                found_s     = found_s | hit_s;
            end
        end
`endif
    end

    // Operand mux: AND-OR over the one-hot grant.
    always_comb begin
        sel_opc_s    = 4'd0;
        sel_pc_sel_s = 1'b0;
        sel_pc_s     = 32'd0;
        sel_reg1_s   = 32'd0;
        sel_src2_s   = 32'd0;
        for (int i = 0; i < N; i++) begin
            sel_opc_s    = sel_opc_s    | (req_opc[4*i +: 4]    & {4{grant_s[i]}});
            sel_pc_sel_s = sel_pc_sel_s | (req_sel_pc[i]        & grant_s[i]);
            sel_pc_s     = sel_pc_s     | (req_pc[32*i +: 32]   & {32{grant_s[i]}});
            sel_reg1_s   = sel_reg1_s   | (req_reg1[32*i +: 32] & {32{grant_s[i]}});
            sel_src2_s   = sel_src2_s   | (req_src2[32*i +: 32] & {32{grant_s[i]}});
        end
    end

    // Grant window: idle, or a response being consumed this cycle.
    always_comb begin
        open_s    = (state_r == IDLE) || ((state_r == RESP) && rsp_ready);
        accept_s  = open_s && (|grant_s);
        req_ready = (rst_n && open_s) ? grant_s : '0;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (!rsp_ready) begin
                    state_nxt_s = RESP;
                end else if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Priority pointer: last accepted index, reset so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 2'(N - 1);
        end else if (accept_s) begin
            ptr_r <= grant_idx_s;
        end
    end
`endif

    // ALU operand registers: change only on accept so ALU inputs stay glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opc    <= 4'd0;
            alu_sel_pc <= 1'b0;
            alu_pc     <= 32'd0;
            alu_reg1   <= 32'd0;
            alu_src2   <= 32'd0;
        end else if (accept_s) begin
            alu_opc    <= sel_opc_s;
            alu_sel_pc <= sel_pc_sel_s;
            alu_pc     <= sel_pc_s;
            alu_reg1   <= sel_reg1_s;
            alu_src2   <= sel_src2_s;
        end
    end

    // Response register: result captured one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 2'd0;
            rsp_data  <= 32'd0;
        end else begin
            if (state_r == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_data  <= alu_result;
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (accept_s) begin
                rsp_id <= grant_idx_s;
            end
        end
    end

endmodule
